wb_regfile_writeback: RTL and testbench
=======================================

# wb_regfile_writeback

Write-back stage and architectural register file for the MIPS pipeline. Consumes the MEM/WB pipeline register outputs (`RegWrite`, `MemtoReg`, `ALUResult`, `RegDstOut`, `MemReadData`, plus `Stall`). Selects the write-back data and commits it to a 32-entry register file. Serves the two ID-stage read ports with write-first bypass and exports the committed write for EX forwarding and retire counting.

## Interface
- `NREG`, 32, number of architectural registers; register 0 is hardwired zero.
- `DATA_W`, 32, register and data width.
- `ADDR_W`, 5, register address width; equals log2(`NREG`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `Stall`  in  1  MEM/WB hold; while high, no commit occurs.
- `RegWrite`  in  1  MEM/WB control: instruction writes a register.
- `MemtoReg`  in  1  MEM/WB control: 1 selects `MemReadData`, 0 selects `ALUResult`.
- `ALUResult`  in  `DATA_W`  MEM/WB ALU result.
- `RegDstOut`  in  `ADDR_W`  MEM/WB destination register.
- `MemReadData`  in  `DATA_W`  MEM/WB load data.
- `RsAddr`, `RtAddr`  in  `ADDR_W`  ID read addresses.
- `RsData`, `RtData`  out  `DATA_W`  ID read data.
- `WB_WriteData`  out  `DATA_W`  selected write-back value (MemtoRegOut).
- `WB_RegWrite`  out  1  commit-qualified write enable, for the forwarding unit.
- `WB_RegDst`  out  `ADDR_W`  equals `RegDstOut`.
- `WbCount`  out  32  number of committed register writes.

## Operation
- `WB_WriteData` = `MemtoReg` ? `MemReadData` : `ALUResult`. It is combinational and is valid regardless of `Stall`.
- Commit condition: `RegWrite` & ~`Stall` & (`RegDstOut` != 0). `WB_RegWrite` equals the commit condition.
- On a commit, `regs[RegDstOut]` <= `WB_WriteData` and `WbCount` <= `WbCount`+1 at the next clock edge. `WbCount` wraps from 0xFFFF_FFFF to 0.
- A write to register 0 is dropped and is not counted.
- Reads are combinational.
  - Address 0 always returns 0.
  - Otherwise, if the commit condition holds and the read address equals `RegDstOut`, the port returns `WB_WriteData` (write-first bypass).
  - Otherwise the port returns the stored value.
- `RsAddr` == `RtAddr` is legal; both ports return the same value.
- `Stall` high with `RegWrite` high: no write, no count, no bypass. The instruction commits exactly once, on the first cycle `Stall` is low.

## Timing
- Reset (`rst_n` low, asynchronous): all registers 1..31 clear to 0 and `WbCount` clears to 0 immediately.
  - Outputs during reset follow the combinational rules: read ports return 0 unless bypassed; `WB_WriteData`, `WB_RegWrite` and `WB_RegDst` follow their inputs.
  - No commit takes effect while `rst_n` is low.
- Reset asserted mid-operation discards any pending commit for that edge. Deassertion is synchronized externally; the first commit can occur at the first rising edge after release.
- Write latency: 1 edge. The stored value is visible on a non-bypassed read in the cycle after the commit.
- Bypass latency: 0 cycles, same-cycle combinational.
- There is no state machine. The sequential state is the register array and `WbCount`.

## Structure
- The shared pipeline package holds `DATA_W`, `ADDR_W`, `NREG` and `typedef logic [DATA_W-1:0] word_t`. The package is also used by the MEM/WB register and the forwarding unit.
- Sub-module `regfile_2r1w` contains the array, the reset clear and two read ports with zero-register handling.
- The top block adds the MemtoReg mux, the commit qualification, the bypass muxes and `WbCount`.

## Test plan
- Reset then read: assert `rst_n`=0 mid-run after writes to r5 and r9 -> `RsData`/`RtData` read 0 for r5 and r9 immediately; `WbCount`=0.
- Basic commit: `RegWrite`=1, `MemtoReg`=0, `ALUResult`=0x1234_5678, `RegDstOut`=7 for one cycle -> `WB_RegWrite`=1, r7 reads 0x1234_5678 next cycle, `WbCount`=1.
- Load select and bypass: `MemtoReg`=1, `MemReadData`=0xDEAD_BEEF, `RegDstOut`=3, `RsAddr`=`RtAddr`=3 in the same cycle -> both read 0xDEAD_BEEF in that cycle, before the edge.
- Stall hold: `Stall`=1 for 3 cycles with `RegWrite`=1, `RegDstOut`=4, data 0xA5A5_A5A5, then `Stall`=0 for 1 cycle.
  - r4 unchanged and no bypass during the stall.
  - Single commit after the stall; `WbCount` increments by exactly 1.
- Register 0: `RegWrite`=1, `RegDstOut`=0, data 0xFFFF_FFFF, read address 0 -> `RsData`=0, `WB_RegWrite`=0, `WbCount` unchanged.
- Counter wrap: force `WbCount` to 0xFFFF_FFFF, then one commit -> `WbCount`=0.

Source files
------------

// File: rtl/wb_regfile_writeback_pkg.sv
// Shared MIPS pipeline definitions: widths, register count and data word type.
// Also imported by the MEM/WB register and the forwarding unit.
package wb_regfile_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/wb_regfile_writeback_regfile.sv
// Architectural register file: two combinational read ports and one write port.
// Register 0 reads as zero and ignores writes.
module regfile_2r1w
  import wb_regfile_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  word_t regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/wb_regfile_writeback.sv
// Write-back stage: selects the result, commits it to the register file,
// bypasses it to the ID read ports and counts retired register writes.
module wb_regfile_writeback
  import wb_regfile_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] RegDstOut,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic              WB_RegWrite,
  output logic [ADDR_W-1:0] WB_RegDst,
  output logic [31:0]       WbCount
);

  word_t       rs_stored;
  word_t       rt_stored;
  logic        commit;
  logic [31:0] wb_count;

  assign WB_WriteData = MemtoReg ? MemReadData : ALUResult;
  assign commit       = RegWrite && !Stall && (RegDstOut != '0);
  assign WB_RegWrite  = commit;
  assign WB_RegDst    = RegDstOut;

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .waddr   (RegDstOut),
    .wdata   (WB_WriteData),
    .raddr_a (RsAddr),
    .raddr_b (RtAddr),
    .rdata_a (rs_stored),
    .rdata_b (rt_stored)
  );

  // Write-first bypass; the zero register never matches because commit excludes it.
  always_comb begin
    RsData = rs_stored;
    RtData = rt_stored;
    if (commit && (RsAddr == RegDstOut)) RsData = WB_WriteData;
    if (commit && (RtAddr == RegDstOut)) RtData = WB_WriteData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (commit) begin
      wb_count <= wb_count + 32'd1;
    end
  end

  assign WbCount = wb_count;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// Self-checking bench: directed vectors with literal expectations plus an
// array-based reference model compared against the DUT on every falling edge.
module tb_wb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ALUResult;
  logic [4:0]  RegDstOut;
  logic [31:0] MemReadData;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [31:0] WB_WriteData;
  logic        WB_RegWrite;
  logic [4:0]  WB_RegDst;
  logic [31:0] WbCount;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  wb_regfile_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Stall        (Stall),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .ALUResult    (ALUResult),
    .RegDstOut    (RegDstOut),
    .MemReadData  (MemReadData),
    .RsAddr       (RsAddr),
    .RtAddr       (RtAddr),
    .RsData       (RsData),
    .RtData       (RtData),
    .WB_WriteData (WB_WriteData),
    .WB_RegWrite  (WB_RegWrite),
    .WB_RegDst    (WB_RegDst),
    .WbCount      (WbCount)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_commit();
    return RegWrite && !Stall && (RegDstOut != 5'd0);
  endfunction

  function automatic logic [31:0] exp_wdata();
    return MemtoReg ? MemReadData : ALUResult;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_commit() && (a == RegDstOut)) return exp_wdata();
    return model_regs[a];
  endfunction

  // Reference model: committed writes land in the array at the rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (exp_commit()) begin
      model_regs[RegDstOut] = exp_wdata();
      model_count = model_count + 32'd1;
    end
  end

  always @(negedge clk) begin
    check_output("model_wdata",  WB_WriteData, exp_wdata());
    check_output("model_regwr",  {31'd0, WB_RegWrite}, {31'd0, exp_commit()});
    check_output("model_regdst", {27'd0, WB_RegDst}, {27'd0, RegDstOut});
    check_output("model_rs",     RsData, exp_read(RsAddr));
    check_output("model_rt",     RtData, exp_read(RtAddr));
    check_output("model_count",  WbCount, model_count);
  end

  task automatic apply_stimulus(input logic rw, input logic m2r, input logic stl,
                                input logic [31:0] alu, input logic [31:0] mrd,
                                input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    @(posedge clk);
    #1;
    RegWrite    = rw;
    MemtoReg    = m2r;
    Stall       = stl;
    ALUResult   = alu;
    MemReadData = mrd;
    RegDstOut   = dst;
    RsAddr      = rs;
    RtAddr      = rt;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Stall = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
    ALUResult = '0; MemReadData = '0; RegDstOut = '0; RsAddr = '0; RtAddr = '0;

    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    check_output("reset_count", WbCount, 32'd0);
    check_output("reset_r1", RsData, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic ALU commit to r7, bypassed in-cycle then stored.
    apply_stimulus(1, 0, 0, 32'h1234_5678, 32'h0BAD_0BAD, 5'd7, 5'd7, 5'd0);
    check_output("basic_regwr", {31'd0, WB_RegWrite}, 32'd1);
    check_output("basic_bypass", RsData, 32'h1234_5678);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    check_output("basic_stored", RsData, 32'h1234_5678);
    check_output("basic_count", WbCount, 32'd1);

    // Load select with both ports bypassing r3.
    apply_stimulus(1, 1, 0, 32'h0000_1111, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd3);
    check_output("load_wdata", WB_WriteData, 32'hDEAD_BEEF);
    check_output("load_rs", RsData, 32'hDEAD_BEEF);
    check_output("load_rt", RtData, 32'hDEAD_BEEF);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
    check_output("load_stored", RsData, 32'hDEAD_BEEF);
    check_output("load_count", WbCount, 32'd2);

    // Stall holds the r4 write for three cycles, then it commits once.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 1, 32'hA5A5_A5A5, 32'h0, 5'd4, 5'd4, 5'd4);
      check_output("stall_rs", RsData, 32'd0);
      check_output("stall_regwr", {31'd0, WB_RegWrite}, 32'd0);
      check_output("stall_count", WbCount, 32'd2);
    end
    apply_stimulus(1, 0, 0, 32'hA5A5_A5A5, 32'h0, 5'd4, 5'd4, 5'd4);
    check_output("unstall_bypass", RtData, 32'hA5A5_A5A5);
    apply_stimulus(0, 0, 0, 32'hA5A5_A5A5, 32'h0, 5'd4, 5'd4, 5'd0);
    check_output("unstall_stored", RsData, 32'hA5A5_A5A5);
    check_output("unstall_count", WbCount, 32'd3);

    // Writes to r0 are dropped and uncounted.
    apply_stimulus(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    check_output("r0_rs", RsData, 32'd0);
    check_output("r0_regwr", {31'd0, WB_RegWrite}, 32'd0);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4);
    check_output("r0_count", WbCount, 32'd3);

    // Fill r5/r9, then reset mid-run clears them at once.
    apply_stimulus(1, 0, 0, 32'h0000_0055, 32'h0, 5'd5, 5'd1, 5'd2);
    apply_stimulus(1, 1, 0, 32'h0, 32'h0000_0099, 5'd9, 5'd5, 5'd2);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9);
    check_output("pre_reset_r5", RsData, 32'h0000_0055);
    check_output("pre_reset_r9", RtData, 32'h0000_0099);
    check_output("pre_reset_count", WbCount, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset_r5", RsData, 32'd0);
    check_output("midreset_r9", RtData, 32'd0);
    check_output("midreset_count", WbCount, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Counter wraps from all-ones to zero on the next commit.
    @(posedge clk); #1;
    force dut.wb_count = 32'hFFFF_FFFF;
    model_count = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count;
    apply_stimulus(1, 0, 0, 32'h0000_0022, 32'h0, 5'd2, 5'd2, 5'd0);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
    check_output("wrap_count", WbCount, 32'd0);
    check_output("wrap_r2", RsData, 32'h0000_0022);

    // Mixed traffic checked by the model only.
    for (int i = 1; i < 32; i++) begin
      apply_stimulus(i[0], i[1], (i % 5) == 0, 32'h1000_0000 + i, 32'h2000_0000 + i,
                     5'(i), 5'(i), 5'(31 - i));
    end
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
